// File: rtl/digit_chain_counter.sv
// Multi-digit up/down stopwatch counter with per-digit moduli, parallel load and wrap pulse.
// Optional lap capture register is built only when LAP_CAPTURE_EN is defined.
module digit_chain_counter #(
    parameter int NUM_DIGITS = 6,
    parameter int DIG_W = 4,
    parameter logic [NUM_DIGITS*DIG_W-1:0] MAX_VEC = 24'h995959
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic                        ctrl,
    input  logic                        set,
    input  logic [NUM_DIGITS*DIG_W-1:0] outsource,
`ifdef LAP_CAPTURE_EN
    input  logic                        lap,
    output logic [NUM_DIGITS*DIG_W-1:0] lap_count,
`endif
    output logic [NUM_DIGITS*DIG_W-1:0] count,
    output logic                        carry_out,
    output logic                        zero
);

    localparam logic [DIG_W-1:0] ONE = 1;

    logic [NUM_DIGITS*DIG_W-1:0] r_count;
    logic                        r_carry;
    logic [NUM_DIGITS*DIG_W-1:0] w_next_count;
    logic                        w_next_carry;
    logic [NUM_DIGITS-1:0]       w_at_max;
    logic [NUM_DIGITS-1:0]       w_at_zero;
    // w_up_en[i] / w_dn_en[i]: every digit below i is at its max / at zero
    logic [NUM_DIGITS:0]         w_up_en;
    logic [NUM_DIGITS:0]         w_dn_en;

    always_comb begin
        w_up_en = '0;
        w_dn_en = '0;
        w_at_max = '0;
        w_at_zero = '0;
        w_up_en[0] = 1'b1;
        w_dn_en[0] = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_at_max[i]  = (r_count[i*DIG_W +: DIG_W] == MAX_VEC[i*DIG_W +: DIG_W]);
            w_at_zero[i] = (r_count[i*DIG_W +: DIG_W] == '0);
            w_up_en[i+1] = w_up_en[i] & w_at_max[i];
            w_dn_en[i+1] = w_dn_en[i] & w_at_zero[i];
        end
    end

    always_comb begin
        w_next_count = r_count;
        w_next_carry = 1'b0;
        if (set) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (outsource[i*DIG_W +: DIG_W] > MAX_VEC[i*DIG_W +: DIG_W])
                    w_next_count[i*DIG_W +: DIG_W] = MAX_VEC[i*DIG_W +: DIG_W];
                else
                    w_next_count[i*DIG_W +: DIG_W] = outsource[i*DIG_W +: DIG_W];
            end
        end else if (tick) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (ctrl) begin
                    if (w_up_en[i])
                        w_next_count[i*DIG_W +: DIG_W] = w_at_max[i] ? '0
                            : r_count[i*DIG_W +: DIG_W] + ONE;
                end else begin
                    if (w_dn_en[i])
                        w_next_count[i*DIG_W +: DIG_W] = w_at_zero[i] ? MAX_VEC[i*DIG_W +: DIG_W]
                            : r_count[i*DIG_W +: DIG_W] - ONE;
                end
            end
            w_next_carry = ctrl ? w_up_en[NUM_DIGITS] : w_dn_en[NUM_DIGITS];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_carry <= w_next_carry;
        end
    end

`ifdef LAP_CAPTURE_EN
    logic [NUM_DIGITS*DIG_W-1:0] r_lap_count;

    // Capture the post-edge value so a lap taken on a tick shows the new time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_lap_count <= '0;
        else if (lap)
            r_lap_count <= w_next_count;
    end

    assign lap_count = r_lap_count;
`endif

    assign count     = r_count;
    assign carry_out = r_carry;
    assign zero      = (r_count == '0);

endmodule

// File: tb/tb_digit_chain_counter.sv
// Bench for digit_chain_counter: mixed-radix integer model, per-cycle compare, directed and random stimulus.
// Exercises the lap capture port as well when LAP_CAPTURE_EN is defined.
module tb_digit_chain_counter;

    localparam int ND = 6;
    localparam int DW = 4;
    localparam int W = ND * DW;
    localparam logic [W-1:0] MAXV = 24'h995959;

    logic         clk;
    logic         reset;
    logic         tick;
    logic         ctrl;
    logic         set;
    logic [W-1:0] outsource;
    logic [W-1:0] count;
    logic         carry_out;
    logic         zero;
`ifdef LAP_CAPTURE_EN
    logic         lap;
    logic [W-1:0] lap_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    digit_chain_counter #(.NUM_DIGITS(ND), .DIG_W(DW), .MAX_VEC(MAXV)) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .ctrl(ctrl),
        .set(set),
        .outsource(outsource),
`ifdef LAP_CAPTURE_EN
        .lap(lap),
        .lap_count(lap_count),
`endif
        .count(count),
        .carry_out(carry_out),
        .zero(zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model: the chain is one mixed-radix integer
    function automatic int radix(input int i);
        logic [W-1:0] mv;
        mv = MAXV;
        return int'(mv[i*DW +: DW]) + 1;
    endfunction

    function automatic longint calc_total();
        longint t = 1;
        for (int i = 0; i < ND; i++) t = t * radix(i);
        return t;
    endfunction

    function automatic longint load_val(input logic [W-1:0] p);
        longint v = 0;
        longint wgt = 1;
        int d;
        for (int i = 0; i < ND; i++) begin
            d = int'(p[i*DW +: DW]);
            if (d > radix(i) - 1) d = radix(i) - 1;
            v = v + longint'(d) * wgt;
            wgt = wgt * radix(i);
        end
        return v;
    endfunction

    function automatic logic [W-1:0] to_packed(input longint v);
        logic [W-1:0] p = '0;
        longint r = v;
        for (int i = 0; i < ND; i++) begin
            p[i*DW +: DW] = DW'(r % radix(i));
            r = r / radix(i);
        end
        return p;
    endfunction

    longint total = calc_total();
    longint m_val;
    bit     m_carry;
    logic [W-1:0] m_lap;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_val = 0;
            m_carry = 0;
            m_lap = '0;
        end else begin
            m_carry = 0;
            if (set) begin
                m_val = load_val(outsource);
            end else if (tick) begin
                if (ctrl) begin
                    if (m_val == total - 1) begin
                        m_val = 0;
                        m_carry = 1;
                    end else begin
                        m_val = m_val + 1;
                    end
                end else begin
                    if (m_val == 0) begin
                        m_val = total - 1;
                        m_carry = 1;
                    end else begin
                        m_val = m_val - 1;
                    end
                end
            end
`ifdef LAP_CAPTURE_EN
            if (lap) m_lap = to_packed(m_val);
`endif
        end
    end

    // ---------------- scoreboard
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_count", count, to_packed(m_val));
            check("cmp_carry", W'(carry_out), W'(m_carry));
            check("cmp_zero", W'(zero), W'(m_val == 0));
`ifdef LAP_CAPTURE_EN
            check("cmp_lap", lap_count, m_lap);
`endif
        end
    end

    // ---------------- driver
    task automatic apply(input logic s, input logic t, input logic c, input logic [W-1:0] o);
        @(negedge clk);
        set = s;
        tick = t;
        ctrl = c;
        outsource = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        ctrl = 1'b1;
        set = 1'b0;
        outsource = '0;
`ifdef LAP_CAPTURE_EN
        lap = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", count, 24'h000000);
        check("reset_carry", W'(carry_out), W'(0));
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1;

        // async reset mid-count, checked between edges
        apply(1, 0, 1, 24'h000123);
        check("t1_loaded", count, 24'h000123);
        reset = 1'b1;
        #1;
        check("t1_async_count", count, 24'h000000);
        check("t1_async_carry", W'(carry_out), W'(0));
        #1;
        reset = 1'b0;

        // up-count across digit boundary
        apply(1, 0, 1, 24'h000059);
        apply(0, 1, 1, '0);
        check("t2_tick1", count, 24'h000100);
        check("t2_carry1", W'(carry_out), W'(0));
        apply(0, 1, 1, '0);
        check("t2_tick2", count, 24'h000101);
        check("t2_carry2", W'(carry_out), W'(0));

        // up wrap
        apply(1, 0, 1, 24'h995959);
        apply(0, 1, 1, '0);
        check("t3_wrap_count", count, 24'h000000);
        check("t3_wrap_carry", W'(carry_out), W'(1));
        apply(0, 0, 1, '0);
        check("t3_carry_drop", W'(carry_out), W'(0));

        // down wrap then borrow across digit
        apply(0, 1, 0, '0);
        check("t4_dwrap_count", count, 24'h995959);
        check("t4_dwrap_carry", W'(carry_out), W'(1));
        apply(1, 0, 0, 24'h000100);
        check("t4_load_carry", W'(carry_out), W'(0));
        apply(0, 1, 0, '0);
        check("t4_borrow", count, 24'h000059);

        // load beats tick, clamps per digit
        apply(1, 1, 1, 24'h0000A7);
        check("t5_clamp", count, 24'h000057);
        check("t5_zero0", W'(zero), W'(0));
        apply(1, 0, 1, 24'h000000);
        check("t5_zero1", W'(zero), W'(1));

        // back-to-back wraps: tick held up/down across zero
        apply(0, 1, 0, '0);
        apply(0, 1, 1, '0);
        check("t7_b2b_count", count, 24'h000000);
        check("t7_b2b_carry", W'(carry_out), W'(1));

`ifdef LAP_CAPTURE_EN
        apply(1, 0, 1, 24'h000010);
        lap = 1'b1;
        apply(0, 1, 1, '0);
        lap = 1'b0;
        check("t6_lap", lap_count, 24'h000011);
        apply(0, 1, 1, '0);
        check("t6_lap_hold", lap_count, 24'h000011);
        check("t6_count", count, 24'h000012);
`endif

        // random phase
        for (int n = 0; n < 3000; n++) begin
            int r;
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            set = 1'b0;
            if (r < 4) begin
                set = 1'b1;
                outsource = W'($urandom());
            end else if (r < 6) begin
                set = 1'b1;
                outsource = MAXV;
            end else if (r < 8) begin
                set = 1'b1;
                outsource = '0;
            end
            tick = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) ctrl = ~ctrl;
`ifdef LAP_CAPTURE_EN
            lap = ($urandom_range(0, 9) == 0);
`endif
        end
        @(negedge clk);
        set = 1'b0;
        tick = 1'b0;
        @(negedge clk);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/digit_chain_counter.md
Name: digit_chain_counter

Overview:
Parametrised multi-digit stopwatch counter: a chain of NUM_DIGITS digit registers, each with its own modulus, counting up or down on an enable tick.
- Supports parallel load and produces a registered whole-chain wrap pulse.
- Replaces hand-wired per-digit counter/mux/register stacks with one block. It sits between the tick generator and the seven-segment display driver.

Parameters:
NUM_DIGITS, 6, number of chained digits; digit 0 is least significant.
DIG_W, 4, bits per digit.
MAX_VEC, 24'h995959, packed per-digit maximum; digit i max = MAX_VEC[i*DIG_W +: DIG_W]; width NUM_DIGITS*DIG_W. Default is HH:MM:SS with maxima 9,9,5,9,5,9 from MSB.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state
tick  input  1  count enable; one step per cycle in which it is high
ctrl  input  1  direction: 1 = up, 0 = down
set  input  1  synchronous parallel load
outsource  input  NUM_DIGITS*DIG_W  load value, packed like MAX_VEC
count  output  NUM_DIGITS*DIG_W  current digit values, packed
carry_out  output  1  registered one-cycle pulse on whole-chain wrap
zero  output  1  combinational; high when every digit is 0

Behaviour:
- Reset (asynchronous, any time, including mid-step): count = 0, carry_out = 0. The first update after deassertion occurs on the next rising edge.
- Per-cycle priority: set > tick > hold.
- Load (set=1):
  - Each digit of outsource above its max is loaded as that max (saturate per digit).
  - The load ignores tick and ctrl.
  - carry_out = 0 in that cycle.
- Up step (tick=1, ctrl=1):
  - digit 0 always steps.
  - Digit i>0 steps only when digits 0..i-1 are all at their max.
  - A stepping digit at max becomes 0; otherwise it increments by 1.
- Down step (tick=1, ctrl=0):
  - Digit i steps only when digits 0..i-1 are all 0.
  - A stepping digit at 0 becomes its max; otherwise it decrements by 1.
- Chain wrap:
  - Up: all digits at max at a tick → all become 0.
  - Down: all digits 0 at a tick → all become max.
  - On either wrap, carry_out = 1 for exactly the following cycle; otherwise carry_out = 0.
- Latency: count and carry_out update on the same edge as the tick that causes them; there is no pipeline.
- ctrl is sampled per tick. Changing direction between ticks takes effect on the next tick, with no dead cycle.
- Illegal digit values cannot arise internally. Only loads can introduce values, and loads are clamped.
- Carry chain is combinational across all digits. At default width, timing closes at the system clock.
- tick held high continuously advances one step per cycle. Back-to-back wraps give back-to-back carry_out pulses.

Optional Feature:
Macro LAP_CAPTURE_EN.
- Defined:
  - Adds input lap (1 bit) and output lap_count (NUM_DIGITS*DIG_W).
  - On a rising edge with lap=1, lap_count captures the value count will hold after that edge. This includes the effect of a simultaneous set or tick.
  - lap_count holds its value otherwise and resets to 0 asynchronously with reset.
- Not defined: lap and lap_count do not exist and no capture register is built.

Test Plan:
1. Reset asserted mid-count at count=24'h000123, asynchronously, no clock edge → count=0, carry_out=0 immediately.
2. Load 24'h000059, ctrl=1, one tick → count=24'h000100; second tick → 24'h000101; carry_out stays 0.
3. Load 24'h995959, ctrl=1, tick → count=0, carry_out=1 for one cycle, then 0.
4. count=0, ctrl=0, tick → count=24'h995959 and carry_out pulse; load 24'h000100, tick → 24'h000059.
5. set=1 with tick=1 in the same cycle, outsource=24'h0000A7 → count=24'h000057 (digit 1 clamped to 5, no step); zero=0; then load 0 → zero=1.
6. LAP_CAPTURE_EN: count=24'h000010, lap=1 with tick=1, ctrl=1 → lap_count=24'h000011. Further ticks leave lap_count unchanged.
